// File: rtl/rd_handshake_ctrl.sv
// Read-handshake controller: strobes a variable-latency memory, waits for mem_ready with a
// timeout, captures the returned word and acknowledges the requester in held or pulse mode.
module rd_handshake_ctrl #(
   parameter int DATA_W    = 8,
   parameter int TIMEOUT   = 15,
   parameter int ACK_PULSE = 0,
   parameter int CNT_W     = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rd,
   input  logic              mem_ready,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              rd_data,
   output logic              ack,
   output logic              err,
   output logic              busy,
   output logic [DATA_W-1:0] rdata_out,
   output logic [CNT_W-1:0]  rd_count
);

   // The wait counter only ever has to reach TIMEOUT-1; keep at least one bit for TIMEOUT=1.
   localparam int                WAIT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_READ    = 3'd1,
      S_ACK_NOW = 3'd2,
      S_HOLD    = 3'd3,
      S_ERR     = 3'd4
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic [WAIT_W-1:0] r_waitCnt;
   logic [WAIT_W-1:0] w_waitNext;
   logic              w_capture;

   always_comb begin
      w_next     = r_state;
      w_waitNext = r_waitCnt;
      w_capture  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (rd) begin
               w_next     = S_READ;
               w_waitNext = '0;
            end
         end
         // A dropped request outranks arriving data, and arriving data outranks the timeout.
         S_READ: begin
            if (!rd) begin
               w_next = S_IDLE;
            end else if (mem_ready) begin
               w_next    = S_ACK_NOW;
               w_capture = 1'b1;
            end else if (r_waitCnt == WAIT_MAX) begin
               w_next = S_ERR;
            end else begin
               w_waitNext = r_waitCnt + WAIT_W'(1);
            end
         end
         S_ACK_NOW: begin
            if (!rd) begin
               w_next = S_IDLE;
            end else if (ACK_PULSE != 0) begin
               w_next = S_HOLD;
            end
         end
         S_HOLD, S_ERR: begin
            if (!rd) begin
               w_next = S_IDLE;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      rd_data = (r_state == S_READ);
      ack     = (r_state == S_ACK_NOW);
      err     = (r_state == S_ERR);
      busy    = (r_state != S_IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= S_IDLE;
         r_waitCnt <= '0;
         rdata_out <= '0;
         rd_count  <= '0;
      end else begin
         r_state   <= w_next;
         r_waitCnt <= w_waitNext;
         if (w_capture) begin
            rdata_out <= mem_rdata;
            rd_count  <= rd_count + CNT_W'(1);
         end
      end
   end

endmodule
